// File: rtl/dcache_req_arb.sv
// ============================================================================
// Module   : dcache_req_arb
// Purpose  : Load/store arbiter in front of the data-cache memory port, with
//            anti-starvation store drain, in-flight load tracking and flush.
// Option   : define DCACHE_REQ_ARB_PERF_EN to build the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dcache_req_arb #(
    parameter int XLEN       = 64,
    parameter int TAG_W      = 8,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 4,
    parameter int DRAIN_LEN  = 2
) (
    input  logic                clk,
    input  logic                rst,
    // load requests
    input  logic                ld_req_valid,
    output logic                ld_req_ready,
    input  logic [XLEN-1:0]     ld_req_addr,
    input  logic [TAG_W-1:0]    ld_req_tag,
    // store requests
    input  logic                st_req_valid,
    output logic                st_req_ready,
    input  logic [XLEN-1:0]     st_req_addr,
    input  logic [XLEN-1:0]     st_req_data,
    input  logic [XLEN/8-1:0]   st_req_mask,
    input  logic                st_urgent,
    // memory side
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    // load responses
    output logic                ld_rsp_valid,
    output logic [TAG_W-1:0]    ld_rsp_tag,
    output logic [XLEN-1:0]     ld_rsp_data,
    input  logic                flush,
    // performance counters
    output logic [31:0]         perf_ld_cnt,
    output logic [31:0]         perf_st_cnt,
    output logic [31:0]         perf_conflict_cnt
);

    localparam int c_ptr_w = $clog2(MAX_OUT);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_stv_w = $clog2(STARVE_MAX + 1);
    localparam int c_drn_w = $clog2(DRAIN_LEN + 1);
    localparam int c_msk_w = XLEN / 8;

    localparam logic [0:0] c_ld_prio  = 1'b0;
    localparam logic [0:0] c_st_drain = 1'b1;

    localparam logic [c_cnt_w-1:0] c_max_out    = c_cnt_w'(MAX_OUT);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(STARVE_MAX);
    localparam logic [c_stv_w-1:0] c_stv_one    = c_stv_w'(1);
    localparam logic [c_drn_w-1:0] c_drain_len  = c_drn_w'(DRAIN_LEN);
    localparam logic [c_drn_w-1:0] c_drn_one    = c_drn_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

    logic [0:0]          state_q,  state_d;
    logic [c_stv_w-1:0]  starve_q, starve_d;
    logic [c_drn_w-1:0]  drain_q,  drain_d;
    logic [c_cnt_w-1:0]  infl_q,   infl_d;
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;

    logic [MAX_OUT-1:0][TAG_W-1:0] w_tags;
    logic [MAX_OUT-1:0]            w_kills;

    logic w_fifo_empty;
    logic w_ld_elig;
    logic w_st_elig;
    logic w_drain_cond;
    logic w_st_prio;
    logic w_sel_st;
    logic w_sel_ld;
    logic w_ld_gnt;
    logic w_st_gnt;
    logic w_pop;
    logic w_pop_kill;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_fifo_empty = (infl_q == '0);
    assign w_ld_elig    = ld_req_valid && (infl_q != c_max_out) && !flush;
    assign w_st_elig    = st_req_valid;

    // Store priority is decided in the same cycle the condition appears, so the
    // first drain grant lands right after the STARVE_MAX-th load grant.
    assign w_drain_cond = (state_q == c_ld_prio) ? (starve_q == c_starve_max)
                                                 : (drain_q < c_drain_len);
    assign w_st_prio    = st_req_valid && (st_urgent || w_drain_cond);

    assign w_sel_st = w_st_elig && (w_st_prio || !w_ld_elig);
    assign w_sel_ld = w_ld_elig && !w_sel_st;
    assign w_ld_gnt = w_sel_ld && mem_ready;
    assign w_st_gnt = w_sel_st && mem_ready;

    assign w_pop      = mem_rvalid && !w_fifo_empty;
    assign w_pop_kill = w_kills[rd_ptr_q];

    // ------------------------------------------------------------------
    // Outputs (all held at zero while reset is asserted)
    // ------------------------------------------------------------------
    assign mem_valid    = !rst && (w_ld_elig || w_st_elig);
    assign mem_we       = !rst && w_sel_st;
    assign mem_addr     = rst      ? '0 :
                          w_sel_st ? st_req_addr :
                          w_sel_ld ? ld_req_addr : '0;
    assign mem_wdata    = (!rst && w_sel_st) ? st_req_data : '0;
    assign mem_wmask    = (!rst && w_sel_st) ? st_req_mask : {c_msk_w{1'b0}};
    assign ld_req_ready = !rst && w_ld_gnt;
    assign st_req_ready = !rst && w_st_gnt;
    assign ld_rsp_valid = !rst && w_pop && !w_pop_kill && !flush;
    assign ld_rsp_tag   = rst ? '0 : w_tags[rd_ptr_q];
    assign ld_rsp_data  = rst ? '0 : mem_rdata;

    // ------------------------------------------------------------------
    // FSM, starvation and drain counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        starve_d = starve_q;

        if (w_st_gnt) begin
            starve_d = '0;
        end else if (w_ld_gnt && st_req_valid && (starve_q != c_starve_max)) begin
            starve_d = starve_q + c_stv_one;
        end

        case (state_q)
            c_ld_prio: begin
                if (w_st_prio) begin
                    state_d = c_st_drain;
                    drain_d = w_st_gnt ? c_drn_one : '0;
                end
            end
            c_st_drain: begin
                if (!w_st_prio) begin
                    state_d = c_ld_prio;
                    drain_d = '0;
                end else if (w_st_gnt && (drain_q != c_drain_len)) begin
                    drain_d = drain_q + c_drn_one;
                end
            end
            default: begin
                state_d = c_ld_prio;
                drain_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // In-flight counter and FIFO pointers
    // ------------------------------------------------------------------
    always_comb begin
        infl_d = infl_q;
        case ({w_ld_gnt, w_pop})
            2'b10:   infl_d = infl_q + c_cnt_one;
            2'b01:   infl_d = infl_q - c_cnt_one;
            default: infl_d = infl_q;
        endcase
        wr_ptr_d = w_ld_gnt ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d = w_pop    ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= c_ld_prio;
            starve_q <= '0;
            drain_q  <= '0;
            infl_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drain_q  <= drain_d;
            infl_q   <= infl_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO entries; an entry is occupied when its distance from the
    // read pointer is below the in-flight count.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_entry
        logic [TAG_W-1:0]   tag_q, tag_d;
        logic               kill_q, kill_d;
        logic [c_ptr_w-1:0] w_rel;
        logic               w_occ;
        logic               w_push;

        assign w_rel  = c_ptr_w'(gi) - rd_ptr_q;
        assign w_occ  = ({1'b0, w_rel} < infl_q);
        assign w_push = w_ld_gnt && (wr_ptr_q == c_ptr_w'(gi));

        always_comb begin
            tag_d  = tag_q;
            kill_d = kill_q | (flush && w_occ);
            if (w_push) begin
                tag_d  = ld_req_tag;
                kill_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_q  <= '0;
                kill_q <= 1'b0;
            end else begin
                tag_q  <= tag_d;
                kill_q <= kill_d;
            end
        end

        assign w_tags[gi]  = tag_q;
        assign w_kills[gi] = kill_q;
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef DCACHE_REQ_ARB_PERF_EN
    logic [31:0] perf_ld_q, perf_ld_d;
    logic [31:0] perf_st_q, perf_st_d;
    logic [31:0] perf_cf_q, perf_cf_d;

    always_comb begin
        perf_ld_d = perf_ld_q + {31'd0, w_ld_gnt};
        perf_st_d = perf_st_q + {31'd0, w_st_gnt};
        perf_cf_d = perf_cf_q + {31'd0, (ld_req_valid && st_req_valid)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ld_q <= '0;
            perf_st_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_ld_q <= perf_ld_d;
            perf_st_q <= perf_st_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_ld_cnt       = perf_ld_q;
    assign perf_st_cnt       = perf_st_q;
    assign perf_conflict_cnt = perf_cf_q;
`else
    assign perf_ld_cnt       = '0;
    assign perf_st_cnt       = '0;
    assign perf_conflict_cnt = '0;
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding is a protocol error upstream.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid |-> !w_fifo_empty);
`endif

endmodule

`default_nettype wire

// File: doc/dcache_req_arb.md
DCACHE_REQ_ARB -- requirements
Module: dcache_req_arb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width.
REQ-002 SHALL have parameter TAG_W, default 8, load tag width.
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum in-flight loads (power of 2, >=2).
REQ-004 SHALL have parameter STARVE_MAX, default 4, load-over-store grants before a forced store drain.
REQ-005 SHALL have parameter DRAIN_LEN, default 2, stores granted per drain burst.
REQ-006 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-007 SHALL have load request ports: ld_req_valid in 1; ld_req_ready out 1; ld_req_addr in XLEN; ld_req_tag in TAG_W.
REQ-008 SHALL have store request ports: st_req_valid in 1; st_req_ready out 1; st_req_addr in XLEN; st_req_data in XLEN; st_req_mask in XLEN/8; st_urgent in 1 (store queue nearly full).
REQ-009 SHALL have memory ports: mem_valid out 1; mem_ready in 1; mem_we out 1; mem_addr out XLEN; mem_wdata out XLEN; mem_wmask out XLEN/8; mem_rvalid in 1; mem_rdata in XLEN (in-order load responses).
REQ-010 SHALL have response ports: ld_rsp_valid out 1; ld_rsp_tag out TAG_W; ld_rsp_data out XLEN; flush in 1 (squash all in-flight loads).
REQ-011 SHALL have perf ports: perf_ld_cnt out 32; perf_st_cnt out 32; perf_conflict_cnt out 32.

Function
REQ-012 SHALL implement a 2-state FSM: LD_PRIO (reset state), ST_DRAIN.
REQ-013 In LD_PRIO, a valid load SHALL win over a valid store, unless the load is blocked (REQ-018, REQ-021).
REQ-014 A 0..STARVE_MAX starvation counter SHALL increment on each load grant while st_req_valid=1, and clear on any store grant.
REQ-015 LD_PRIO SHALL go to ST_DRAIN when st_urgent=1, or when the counter reaches STARVE_MAX, with st_req_valid=1.
REQ-016 In ST_DRAIN, stores SHALL have strict priority.
REQ-017 ST_DRAIN SHALL return to LD_PRIO after DRAIN_LEN store grants or when st_req_valid=0, whichever is first; st_urgent=1 SHALL extend the burst.
REQ-018 A grant SHALL occur only when mem_ready=1; at most one grant per cycle.
REQ-019 The memory request SHALL be combinational from the winner: mem_valid=1 when any eligible request exists; mem_we=1 for a store.
REQ-020 Store grants SHALL drive mem_addr, mem_wdata, mem_wmask from the st_req ports. Load grants SHALL drive mem_addr from ld_req_addr, with mem_wdata=0 and mem_wmask=0.
REQ-021 An in-flight counter of width clog2(MAX_OUT)+1 SHALL be kept. Loads are blocked when the counter equals MAX_OUT. Load grant +1, mem_rvalid -1; simultaneous grant and response SHALL leave it unchanged.
REQ-022 A MAX_OUT-deep circular tag FIFO SHALL record {tag, kill=0} per load grant and pop on mem_rvalid; pointers SHALL wrap modulo MAX_OUT.
REQ-023 ld_rsp_valid SHALL equal mem_rvalid AND NOT popped kill AND NOT flush, with zero added latency. ld_rsp_tag SHALL be the popped tag; ld_rsp_data SHALL equal mem_rdata.
REQ-024 flush=1 SHALL set kill on every occupied FIFO entry and force ld_req_ready=0 that cycle. Store traffic and FSM state SHALL be unaffected.
REQ-025 Killed entries SHALL still consume a response and a counter decrement.
REQ-026 mem_rvalid with an empty FIFO is illegal. It SHALL be ignored, and a non-synthesis assertion SHALL fire.
REQ-027 ld_req_ready and st_req_ready SHALL equal "this requester granted this cycle".

Reset
REQ-028 rst SHALL asynchronously force: FSM=LD_PRIO; starvation, drain and in-flight counters=0; FIFO pointers=0; all kill bits=0.
REQ-029 During reset, all outputs SHALL be 0, including the ready, mem_valid, ld_rsp_valid and perf outputs.
REQ-030 Responses arriving after a mid-operation reset SHALL be dropped, as the FIFO is empty (REQ-026).

Configuration
REQ-031 Macro DCACHE_REQ_ARB_PERF_EN SHALL control the perf counters.
REQ-032 When defined: perf_ld_cnt SHALL count load grants and perf_st_cnt store grants; perf_conflict_cnt SHALL count cycles with both requests valid. All three are 32-bit wrapping and reset to 0.
REQ-033 When undefined: all three perf outputs SHALL be tied to 0 and no counter flops SHALL be instantiated.

Verification
REQ-034 Load and store valid every cycle, mem_ready=1, STARVE_MAX=4, DRAIN_LEN=2 -> grant pattern L,L,L,L,S,S,L,L,L,L,S,S...
REQ-035 st_urgent=1 held for 5 cycles with both valid -> 5 consecutive store grants, then loads resume.
REQ-036 5 loads issued with MAX_OUT=4, no responses -> 4 grants, then ld_req_ready=0. One mem_rvalid -> 5th load granted the following cycle.
REQ-037 3 loads in flight (tags 0x11,0x22,0x33), flush, then 3 responses -> ld_rsp_valid never 1, and the counter returns to 0.
REQ-038 rst pulsed asynchronously mid-cycle while 2 loads are in flight -> all outputs 0 immediately; after release FSM=LD_PRIO and counter=0.
REQ-039 With DCACHE_REQ_ARB_PERF_EN, 10 cycles of both valid -> perf_conflict_cnt=10 and perf_ld_cnt+perf_st_cnt=10; without the macro -> all perf outputs 0.
